// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared types and constants for the NES-to-VGA line scaler.
//  - rgb_t        : pixel word at the default channel width, {blue,green,red}
//  - *_CH         : channel position inside a pixel word (lsb = CH * channel width)
//  - pix_src_e    : what the registered output stage presents
//  - clog2        : elaboration-time ceil(log2)
// -----------------------------------------------------------------------------
package video_pkg;

  localparam int NES_VISIBLE_WIDTH = 256;
  localparam int RGB_BITWIDTH_DEF  = 8;

  // Channel order inside a pixel word, red in the LSBs.
  localparam int RED_CH   = 0;
  localparam int GREEN_CH = 1;
  localparam int BLUE_CH  = 2;

  typedef logic [3*RGB_BITWIDTH_DEF-1:0] rgb_t;

  // Output source selected one cycle ahead of the RAM data.
  // PIX_ZERO exists only so the outputs read all-zero straight out of reset.
  typedef enum logic [1:0] {
    PIX_ZERO   = 2'd0,
    PIX_BORDER = 2'd1,
    PIX_IMAGE  = 2'd2,
    PIX_DIMMED = 2'd3
  } pix_src_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/video_line_ram.sv
// -----------------------------------------------------------------------------
// video_line_ram
// Line storage for the scaler: DEPTH words, one synchronous write port and one
// read port whose data is registered (maps onto block RAM).
// Ports:
//  i_clk    clock
//  i_we     write enable
//  i_waddr  write address {line select, pixel index}
//  i_wdata  write data
//  i_raddr  read address {line select, pixel index}
//  o_rdata  read data, valid one cycle after i_raddr
// -----------------------------------------------------------------------------
module video_line_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/video_line_scaler.sv
// -----------------------------------------------------------------------------
// video_line_scaler
// Line-buffer scaler between the NES pixel FIFO and the VGA timing generator.
// A ring of NUM_LINES source lines: the FIFO side fills a back line while the
// VGA side shows the front line, each pixel repeated H_SCALE times across and
// each line repeated for V_SCALE VGA lines.
// Optional feature macro: VIDEO_SCANLINE_DIM_EN -- repetitions other than the
// first of each source line show every channel halved (border stays undimmed).
// Ports:
//  i_clk, i_reset_n        clock, asynchronous active-low reset
//  i_pixel_valid/o_pixel_ready/i_pixel_rgb   FIFO handshake and pixel word
//  i_vga_x                 x of the pixel VGA renders next cycle
//  i_vga_line_end          one-cycle pulse at the end of each VGA line
//  o_vga_reset_n           holds VGA timing in reset until the first line lands
//  o_vga_red/green/blue    pixel channels, one cycle after i_vga_x
//  o_underflow             sticky: a line advance found no committed line
//  o_lines_full            committed-line count
// -----------------------------------------------------------------------------
module video_line_scaler
  import video_pkg::*;
#(
  parameter int PIXEL_BITWIDTH = 11,
  parameter int RGB_BITWIDTH   = 8,
  parameter int SRC_WIDTH      = NES_VISIBLE_WIDTH,
  parameter int NUM_LINES      = 2,
  parameter int H_SCALE        = 2,
  parameter int V_SCALE        = 2,
  parameter int H_OFFSET       = 0,
  parameter logic [3*RGB_BITWIDTH-1:0] BORDER_RGB = '0
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic                              i_pixel_valid,
  output logic                              o_pixel_ready,
  input  logic [3*RGB_BITWIDTH-1:0]         i_pixel_rgb,
  input  logic [PIXEL_BITWIDTH-1:0]         i_vga_x,
  input  logic                              i_vga_line_end,
  output logic                              o_vga_reset_n,
  output logic [RGB_BITWIDTH-1:0]           o_vga_red,
  output logic [RGB_BITWIDTH-1:0]           o_vga_green,
  output logic [RGB_BITWIDTH-1:0]           o_vga_blue,
  output logic                              o_underflow,
  output logic [clog2(NUM_LINES+1)-1:0]     o_lines_full
);

  localparam int IDX_W  = (clog2(SRC_WIDTH) < 1) ? 1 : clog2(SRC_WIDTH);
  localparam int SEL_W  = (clog2(NUM_LINES) < 1) ? 1 : clog2(NUM_LINES);
  localparam int CNT_W  = clog2(NUM_LINES + 1);
  localparam int REP_W  = (clog2(V_SCALE) < 1) ? 1 : clog2(V_SCALE);
  localparam int HS_SH  = clog2(H_SCALE);
  localparam int PIX_W  = 3 * RGB_BITWIDTH;
  localparam int IMG_W  = SRC_WIDTH * H_SCALE;
  localparam int ADDR_W = SEL_W + IDX_W;

  logic [IDX_W-1:0]   r_wr_idx;
  logic [SEL_W-1:0]   r_wr_sel;
  logic [SEL_W-1:0]   r_rd_sel;
  logic [CNT_W-1:0]   r_count;
  logic [REP_W-1:0]   r_rep;
  logic               r_vga_on;
  logic               r_underflow;
  pix_src_e           r_src_p1;

  logic               w_xfer;
  logic               w_commit;
  logic               w_line_rel;
  logic               w_adv;
  logic               w_under;
  logic [PIXEL_BITWIDTH-1:0] w_xr;
  logic               w_inside;
  logic [IDX_W-1:0]   w_idx;
  pix_src_e           w_src_p0;
  logic [PIX_W-1:0]   w_ram_rdata;
  logic [PIX_W-1:0]   w_pix_p1;

  function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] s);
    return (32'(s) == NUM_LINES - 1) ? '0 : s + 1'b1;
  endfunction

  // Halve each channel independently so no bit leaks across channels.
  function automatic logic [PIX_W-1:0] dim_pix(input logic [PIX_W-1:0] p);
    logic [PIX_W-1:0] d;
    d = '0;
    for (int c = 0; c < 3; c++)
      d[c*RGB_BITWIDTH +: RGB_BITWIDTH] = p[c*RGB_BITWIDTH +: RGB_BITWIDTH] >> 1;
    return d;
  endfunction

  // ---- write side / line ring control ----
  assign o_pixel_ready = (32'(r_count) < NUM_LINES);
  assign w_xfer        = i_pixel_valid && o_pixel_ready;
  assign w_commit      = w_xfer && (32'(r_wr_idx) == SRC_WIDTH - 1);
  // A release happens on the last of the V_SCALE repetitions of the front line;
  // with only one committed line the front line is shown again instead.
  assign w_line_rel    = i_vga_line_end && r_vga_on && (32'(r_rep) == V_SCALE - 1);
  assign w_adv         = w_line_rel && (32'(r_count) >= 2);
  assign w_under       = w_line_rel && !w_adv;

  // ---- read address (stage p0) ----
  assign w_xr     = i_vga_x - PIXEL_BITWIDTH'(H_OFFSET);
  assign w_inside = (32'(i_vga_x) >= H_OFFSET) && (32'(w_xr) < IMG_W);
  assign w_idx    = IDX_W'(w_xr >> HS_SH);

  always_comb begin
    w_src_p0 = PIX_BORDER;
    if (r_vga_on && w_inside) begin
`ifdef VIDEO_SCANLINE_DIM_EN
      w_src_p0 = (r_rep != '0) ? PIX_DIMMED : PIX_IMAGE;
`else
      w_src_p0 = PIX_IMAGE;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_idx    <= '0;
      r_wr_sel    <= '0;
      r_rd_sel    <= '0;
      r_count     <= '0;
      r_rep       <= '0;
      r_vga_on    <= 1'b0;
      r_underflow <= 1'b0;
      r_src_p1    <= PIX_ZERO;
    end else begin
      if (w_xfer) r_wr_idx <= w_commit ? '0 : r_wr_idx + 1'b1;
      if (w_commit) begin
        r_wr_sel <= next_sel(r_wr_sel);
        r_vga_on <= 1'b1;
      end
      if (w_adv) r_rd_sel <= next_sel(r_rd_sel);
      case ({w_commit, w_adv})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_vga_line_end && r_vga_on) r_rep <= w_line_rel ? '0 : r_rep + 1'b1;
      if (w_under) r_underflow <= 1'b1;
      r_src_p1 <= w_src_p0;
    end
  end

  video_line_ram #(
    .DATA_W (PIX_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (NUM_LINES << IDX_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_xfer),
    .i_waddr ({r_wr_sel, r_wr_idx}),
    .i_wdata (i_pixel_rgb),
    .i_raddr ({r_rd_sel, w_idx}),
    .o_rdata (w_ram_rdata)
  );

  // ---- output (stage p1) ----
  // The RAM read register is the output register; the mux selects on a flag
  // registered alongside it, so no extra latency is added.
  always_comb begin
    case (r_src_p1)
      PIX_ZERO:   w_pix_p1 = '0;
      PIX_BORDER: w_pix_p1 = BORDER_RGB;
      PIX_DIMMED: w_pix_p1 = dim_pix(w_ram_rdata);
      default:    w_pix_p1 = w_ram_rdata;
    endcase
  end

  assign o_vga_red     = w_pix_p1[RED_CH*RGB_BITWIDTH   +: RGB_BITWIDTH];
  assign o_vga_green   = w_pix_p1[GREEN_CH*RGB_BITWIDTH +: RGB_BITWIDTH];
  assign o_vga_blue    = w_pix_p1[BLUE_CH*RGB_BITWIDTH  +: RGB_BITWIDTH];
  assign o_vga_reset_n = r_vga_on;
  assign o_underflow   = r_underflow;
  assign o_lines_full  = r_count;

endmodule

// File: tb/tb_video_line_scaler.sv
// -----------------------------------------------------------------------------
// tb_video_line_scaler
// Self-checking bench: a reference model of the line ring predicts every pixel
// word; predictions are queued when i_vga_x is driven and compared when the
// registered output appears one cycle later.
// -----------------------------------------------------------------------------
module tb_video_line_scaler;
  import video_pkg::*;

  localparam int                H_OFF  = 64;
  localparam logic [23:0]       BORDER = 24'hA5C35A;
  localparam int                SRC_W  = 256;
  localparam int                NLINES = 2;
  localparam int                VSC    = 2;
  localparam int                HSC    = 2;

  logic        clk;
  logic        rst_n;
  logic        pix_valid;
  logic        pix_ready;
  logic [23:0] pix_rgb;
  logic [10:0] vga_x;
  logic        line_end;
  logic        vga_rst_n;
  logic [7:0]  red, green, blue;
  logic        underflow;
  logic [1:0]  lines_full;

  int   n_checks;
  int   n_fail;
  rgb_t exp_q[$];

  // reference model state
  int   m_lines[$];
  int   m_rep;
  int   m_wr_idx;
  bit   m_on;
  bit   m_under;

  video_line_scaler #(
    .PIXEL_BITWIDTH (11),
    .RGB_BITWIDTH   (8),
    .SRC_WIDTH      (SRC_W),
    .NUM_LINES      (NLINES),
    .H_SCALE        (HSC),
    .V_SCALE        (VSC),
    .H_OFFSET       (H_OFF),
    .BORDER_RGB     (BORDER)
  ) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_pixel_valid  (pix_valid),
    .o_pixel_ready  (pix_ready),
    .i_pixel_rgb    (pix_rgb),
    .i_vga_x        (vga_x),
    .i_vga_line_end (line_end),
    .o_vga_reset_n  (vga_rst_n),
    .o_vga_red      (red),
    .o_vga_green    (green),
    .o_vga_blue     (blue),
    .o_underflow    (underflow),
    .o_lines_full   (lines_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic rgb_t exp_pix(input int x);
    int i;
    logic [7:0] r, g, b;
    if (!m_on || x < H_OFF || x >= H_OFF + SRC_W * HSC) return BORDER;
    i = (x - H_OFF) / HSC;
    r = 8'(i);
    g = 8'(m_lines[0]);
    b = 8'(i);
`ifdef VIDEO_SCANLINE_DIM_EN
    if (m_rep != 0) begin
      r = r >> 1;
      g = g >> 1;
      b = b >> 1;
    end
`endif
    return {b, g, r};
  endfunction

  task automatic model_reset();
    m_lines.delete();
    m_rep    = 0;
    m_wr_idx = 0;
    m_on     = 0;
    m_under  = 0;
  endtask

  // Push one pixel, waiting (bounded) for ready; model follows the transfer.
  task automatic push_px(input int line_id, input int idx);
    bit done;
    done      = 0;
    pix_valid = 1'b1;
    pix_rgb   = {8'(idx), 8'(line_id), 8'(idx)};
    for (int t = 0; t < 20 && !done; t++) begin
      if (pix_ready) done = 1;
      tick();
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: ready stayed %0b, required 1", pix_ready);
    end else begin
      m_wr_idx++;
      if (m_wr_idx == SRC_W) begin
        m_wr_idx = 0;
        m_lines.push_back(line_id);
        m_on = 1;
      end
    end
  endtask

  task automatic push_line(input int line_id);
    for (int i = 0; i < SRC_W; i++) push_px(line_id, i);
    pix_valid = 1'b0;
  endtask

  task automatic pulse_line_end();
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
    if (m_on) begin
      if (m_rep < VSC - 1) m_rep++;
      else begin
        m_rep = 0;
        if (m_lines.size() >= 2) void'(m_lines.pop_front());
        else m_under = 1;
      end
    end
  endtask

  task automatic read_x(input int x, input string nm);
    rgb_t got, exp;
    vga_x = 11'(x);
    exp_q.push_back(exp_pix(x));
    tick();
    got = {blue, green, red};
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s x=%0d: got %h required %h", nm, x, got, exp);
    end
  endtask

  task automatic check_status(input string nm);
    n_checks++;
    if (vga_rst_n !== m_on) begin
      n_fail++;
      $display("FAIL %s vga_reset_n: got %b required %b", nm, vga_rst_n, m_on);
    end
    n_checks++;
    if (lines_full !== 2'(m_lines.size())) begin
      n_fail++;
      $display("FAIL %s lines_full: got %0d required %0d", nm, lines_full, m_lines.size());
    end
    n_checks++;
    if (pix_ready !== (m_lines.size() < NLINES)) begin
      n_fail++;
      $display("FAIL %s ready: got %b required %b", nm, pix_ready, m_lines.size() < NLINES);
    end
    n_checks++;
    if (underflow !== m_under) begin
      n_fail++;
      $display("FAIL %s underflow: got %b required %b", nm, underflow, m_under);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) push_px(7, i);
    pix_valid = 1'b0;
    tick();
    // asynchronous assertion, checked before the next clock edge
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({blue, green, red} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_rgb: got %h required 000000", {blue, green, red});
    end
    check_status("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_read();
    push_line(0);
    check_status("fill");
    for (int x = 0; x < 640; x++) read_x(x, "fill_read");
  endtask

  task automatic test_backpressure();
    push_line(1);
    check_status("full");
    pix_valid = 1'b1;
    pix_rgb   = {8'd0, 8'd2, 8'd0};
    for (int t = 0; t < 5; t++) begin
      tick();
      check_status("hold");
    end
    pix_valid = 1'b0;
  endtask

  task automatic test_release();
    pulse_line_end();
    check_status("rep1");
    for (int x = 60; x < 80; x++) read_x(x, "rep1_read");
    pulse_line_end();
    check_status("release");
    for (int x = 60; x < 600; x += 3) read_x(x, "release_read");
  endtask

  task automatic test_underflow();
    pulse_line_end();
    pulse_line_end();
    check_status("underflow");
    for (int x = 64; x < 100; x++) read_x(x, "underflow_read");
    push_line(2);
    check_status("after_commit");
  endtask

  task automatic test_offset_border();
    int xs[8];
    xs = '{0, 63, 64, 65, 574, 575, 576, 2047};
    foreach (xs[i]) read_x(xs[i], "offset_rep0");
    pulse_line_end();
    foreach (xs[i]) read_x(xs[i], "offset_rep1");
    for (int x = 100; x < 140; x++) read_x(x, "back_to_back");
    check_status("final");
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_rgb   = '0;
    vga_x     = '0;
    line_end  = 1'b0;
    test_reset();
    test_fill_read();
    test_backpressure();
    test_release();
    test_underflow();
    test_offset_border();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
